seg7_mmio_ctrl: RTL and testbench
=================================

// Module: seg7_mmio_ctrl
// PURPOSE
//  Memory-mapped 7-segment display responder on the core's data-store bus at BASE_ADDR (0x400).
//  Latches segment patterns written by software and time-multiplexes them onto NUM_DIGITS common-anode/cathode digits.
//  Provides register readback and a change-pulse for monitors.
// PARAMETERS
//  XLEN        32      bus address/data width
//  BASE_ADDR   32'h400 base of register window (aligned to 0x40)
//  NUM_DIGITS  4       digits driven, 1..8
//  SCAN_DIV    1000    clocks each digit stays selected, >=1
//  ACTIVE_LOW  0       1: invert seg_o, dp_o, an_o at the pins
// PORTS
//  clk_i      in   1           core clock
//  rst_i      in   1           async reset, active-high
//  wr_en_i    in   1           store strobe, one cycle per store
//  wr_addr_i  in   XLEN        store byte address
//  wr_data_i  in   XLEN        store data
//  wr_strb_i  in   4           byte enables
//  rd_en_i    in   1           load strobe
//  rd_addr_i  in   XLEN        load byte address
//  rd_data_o  out  XLEN        load data, valid with rd_valid_o
//  rd_valid_o out  1           one-cycle pulse answering rd_en_i
//  seg_o      out  7           segments a..g = bit0..6
//  dp_o       out  1           decimal point
//  an_o       out  NUM_DIGITS  one-hot digit select
//  upd_o      out  1           one-cycle pulse: a digit register changed value
// BEHAVIOUR
//  Register map, offsets from BASE_ADDR:
//  - 0x00+4k: DIGITk[7:0], k<NUM_DIGITS; bit7=dp, [6:0]=segments. R/W; reset 0x00.
//  - 0x20: CTRL. bit0 EN (reset 1), bit1 BLANK (reset 0). R/W.
//  - 0x24: HEX, write-only (see CONFIGURATION). Reads return 0.
//  Writes:
//  - Take effect at the rising edge where wr_en_i=1.
//  - Require wr_strb_i[0]; other byte lanes ignored.
//  - Addresses outside the map or k>=NUM_DIGITS: ignored.
//  Reads: rd_valid_o=1 and rd_data_o set on the edge after rd_en_i; upper bits zero. Unmapped offsets return 0.
//    Same-cycle read+write to one register returns the OLD value.
//  upd_o: asserted the edge after any write whose new DIGITk content differs from old; same-value rewrite gives no pulse.
//  Scan:
//  - div counter 0..SCAN_DIV-1; at terminal count, idx advances, NUM_DIGITS-1 wraps to 0.
//  - EN=0: div and idx held at 0, an_o all inactive.
//  - BLANK=1: scanning continues, an_o all inactive.
//  Outputs: seg_o/dp_o/an_o are registered from idx and DIGIT[idx] (1-cycle latency).
//    A write to the selected digit shows on the pins one edge after the register updates.
//  Reset (async, anytime incl. mid-scan):
//  - immediately an_o, seg_o, dp_o inactive (polarity per ACTIVE_LOW); rd_data_o=0, rd_valid_o=0, upd_o=0;
//  - div=0, idx=0; registers to reset values.
//  - First digit-0 select appears 1 edge after rst_i deasserts.
// CONFIGURATION
//  SEG7_HEX_DECODE_EN defined:
//  - write to 0x24: nibble k of wr_data_i (bits 4k+3:4k) decoded into DIGITk[6:0] for every k<NUM_DIGITS, dp cleared.
//    All strobes ignored for this register.
//  - Table 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//  - upd_o as for a direct write if any digit changes.
//  Not defined: 0x24 unmapped; writes ignored, no decoder logic.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0 unless noted)
//  1 Reset asserted -> an_o=0, seg_o=0, upd_o=0; read 0x420 after release -> 0x1.
//  2 Store 0x5B to 0x400 -> upd_o pulse next edge; read 0x400 -> 0x5B;
//    seg_o=0x5B while an_o=0001.
//  3 Free-running scan -> an_o 0001,0010,0100,1000,0001, each held exactly 4 clocks.
//  4 Re-store 0x5B to 0x400; store 0x06 to 0x410 (k=4 out of range) -> no upd_o; 0x410 reads 0.
//  5 SEG7_HEX_DECODE_EN: store 0x0000A930 to 0x424 -> DIGIT0..3 = 3F,4F,6F,77.
//    Without macro -> no change.
//  6 Assert rst_i between clock edges mid-scan -> an_o=0 before next edge;
//    CTRL write 0x0 -> an_o=0, idx stays 0.

Source files
------------

// File: rtl/seg7_mmio_ctrl.sv
// Memory-mapped 7-segment display controller: digit/CTRL registers with readback, change pulse and scan mux.
// Optional macro SEG7_HEX_DECODE_EN adds a write-only HEX register at offset 0x24 that decodes nibbles into all digits.
module seg7_mmio_ctrl #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_0400,
   parameter int              NUM_DIGITS = 4,
   parameter int              SCAN_DIV   = 1000,
   parameter int              ACTIVE_LOW = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [XLEN-1:0]       wr_addr_i,
   input  logic [XLEN-1:0]       wr_data_i,
   input  logic [3:0]            wr_strb_i,
   input  logic                  rd_en_i,
   input  logic [XLEN-1:0]       rd_addr_i,
   output logic [XLEN-1:0]       rd_data_o,
   output logic                  rd_valid_o,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic                  upd_o
);

   localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic             POL      = (ACTIVE_LOW != 0);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

`ifdef SEG7_HEX_DECODE_EN
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         4'hF: hex_to_seg = 7'h71;
         default: hex_to_seg = 7'h00;
      endcase
   endfunction
`endif

   logic [NUM_DIGITS-1:0][7:0] digit_r;
   logic [NUM_DIGITS-1:0][7:0] digit_nxt_s;
   logic                       en_r;
   logic                       blank_r;
   logic [DIV_W-1:0]           div_r;
   logic [IDX_W-1:0]           idx_r;
   logic [6:0]                 seg_r;
   logic                       dp_r;
   logic [NUM_DIGITS-1:0]      an_r;
   logic                       upd_r;
   logic                       rd_valid_r;
   logic [XLEN-1:0]            rd_data_r;

   logic                       wr_act_s;
   logic                       rd_win_s;
   logic [5:0]                 wr_off_s;
   logic [5:0]                 rd_off_s;
   logic                       ctrl_wr_s;
   logic                       hex_wr_s;
   logic                       upd_s;
   logic [XLEN-1:0]            rd_mux_s;
   logic [7:0]                 cur_digit_s;
   logic [NUM_DIGITS-1:0]      an_sel_s;
   logic                       unused_s;

   // Only word-aligned addresses inside the 64-byte window decode.
   assign wr_act_s = wr_en_i && (wr_addr_i[XLEN-1:6] == BASE_ADDR[XLEN-1:6]) && (wr_addr_i[1:0] == 2'b00);
   assign rd_win_s = (rd_addr_i[XLEN-1:6] == BASE_ADDR[XLEN-1:6]) && (rd_addr_i[1:0] == 2'b00);
   assign wr_off_s = wr_addr_i[5:0];
   assign rd_off_s = rd_addr_i[5:0];
   assign unused_s = ^{wr_strb_i[3:1], wr_data_i};

   // Next digit contents and control-write decode for the current store.
   always_comb begin
      ctrl_wr_s = wr_act_s && wr_strb_i[0] && (wr_off_s == 6'h20);
`ifdef SEG7_HEX_DECODE_EN
      hex_wr_s  = wr_act_s && (wr_off_s == 6'h24);
`else
      hex_wr_s  = 1'b0;
`endif
      digit_nxt_s = digit_r;
      for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef SEG7_HEX_DECODE_EN
         digit_nxt_s[k] = hex_wr_s ? {1'b0, hex_to_seg(wr_data_i[4*k +: 4])} :
                          (wr_act_s && wr_strb_i[0] && (wr_off_s == 6'(4*k))) ? wr_data_i[7:0] : digit_r[k];
`else
         digit_nxt_s[k] = (wr_act_s && wr_strb_i[0] && (wr_off_s == 6'(4*k))) ? wr_data_i[7:0] : digit_r[k];
`endif
      end
      upd_s = (digit_nxt_s != digit_r);
   end

   // Read mux built from current (pre-write) register values.
   always_comb begin
      rd_mux_s = {XLEN{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         rd_mux_s[7:0] = (rd_win_s && (rd_off_s == 6'(4*k))) ? digit_r[k] : rd_mux_s[7:0];
      end
      rd_mux_s[1:0] = (rd_win_s && (rd_off_s == 6'h20)) ? {blank_r, en_r} : rd_mux_s[1:0];
   end

   // Select the digit addressed by the scan index.
   always_comb begin
      cur_digit_s = 8'h00;
      an_sel_s    = {NUM_DIGITS{1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         cur_digit_s = (idx_r == IDX_W'(k)) ? digit_r[k] : cur_digit_s;
         an_sel_s[k] = (idx_r == IDX_W'(k));
      end
   end

   // Register file, change pulse and read response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         digit_r    <= {NUM_DIGITS{8'h00}};
         en_r       <= 1'b1;
         blank_r    <= 1'b0;
         upd_r      <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= {XLEN{1'b0}};
      end else begin
         digit_r    <= digit_nxt_s;
         if (ctrl_wr_s) begin
            en_r    <= wr_data_i[0];
            blank_r <= wr_data_i[1];
         end
         upd_r      <= upd_s;
         rd_valid_r <= rd_en_i;
         rd_data_r  <= rd_en_i ? rd_mux_s : {XLEN{1'b0}};
      end
   end

   // Scan divider and digit index; both parked at zero while disabled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_r <= {DIV_W{1'b0}};
         idx_r <= {IDX_W{1'b0}};
      end else if (!en_r) begin
         div_r <= {DIV_W{1'b0}};
         idx_r <= {IDX_W{1'b0}};
      end else if (div_r == DIV_LAST) begin
         div_r <= {DIV_W{1'b0}};
         idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + 1'b1;
      end else begin
         div_r <= div_r + 1'b1;
      end
   end

   // Pin registers hold pin-level polarity so reset is inactive directly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         seg_r <= {7{POL}};
         dp_r  <= POL;
         an_r  <= {NUM_DIGITS{POL}};
      end else begin
         seg_r <= cur_digit_s[6:0] ^ {7{POL}};
         dp_r  <= cur_digit_s[7] ^ POL;
         an_r  <= (en_r && !blank_r) ? (an_sel_s ^ {NUM_DIGITS{POL}}) : {NUM_DIGITS{POL}};
      end
   end

   assign seg_o      = seg_r;
   assign dp_o       = dp_r;
   assign an_o       = an_r;
   assign upd_o      = upd_r;
   assign rd_valid_o = rd_valid_r;
   assign rd_data_o  = rd_data_r;

endmodule

// File: tb/tb_seg7_mmio_ctrl.sv
// Self-checking bench for seg7_mmio_ctrl with NUM_DIGITS=4, SCAN_DIV=4 against an arithmetic reference model.
module tb_seg7_mmio_ctrl;
   localparam int N  = 4;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   logic [3:0]    wr_strb;
   logic          rd_en;
   logic [31:0]   rd_addr;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic [6:0]    seg;
   logic          dp;
   logic [N-1:0]  an;
   logic          upd;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0]    m_dig [N];
   logic          m_en;
   logic          m_blank;
   int            m_cnt;
   logic [6:0]    hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   // expected outputs after the next edge
   logic [N-1:0]  e_an;
   logic [6:0]    e_seg;
   logic          e_dp;
   logic          e_upd;
   logic          e_rv;
   logic [31:0]   e_rd;

   seg7_mmio_ctrl #(.XLEN(32), .BASE_ADDR(32'h400), .NUM_DIGITS(N), .SCAN_DIV(SD), .ACTIVE_LOW(0)) dut (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_strb_i(wr_strb), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .rd_valid_o(rd_valid), .seg_o(seg), .dp_o(dp), .an_o(an), .upd_o(upd));

   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int off;
      if (a < 32'h400 || a >= 32'h440 || a[1:0] != 2'b00) return 32'd0;
      off = int'(a - 32'h400);
      if (off < 32 && off / 4 < N) return {24'd0, m_dig[off / 4]};
      if (off == 32) return {30'd0, m_blank, m_en};
      return 32'd0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) m_dig[k] = 8'h00;
      m_en = 1'b1; m_blank = 1'b0; m_cnt = 0;
   endtask

   // advance one clock edge; model predicts from the pre-edge state and current inputs
   task automatic step();
      int pos;
      int off;
      logic [7:0] nd [N];
      pos   = (m_cnt / SD) % N;
      e_an  = (m_en && !m_blank) ? N'(1 << pos) : {N{1'b0}};
      e_seg = m_dig[pos][6:0];
      e_dp  = m_dig[pos][7];
      e_rv  = rd_en;
      e_rd  = rd_en ? model_read(rd_addr) : 32'd0;
      m_cnt = m_en ? m_cnt + 1 : 0;
      nd = m_dig;
      if (wr_en && wr_addr >= 32'h400 && wr_addr < 32'h440 && wr_addr[1:0] == 2'b00) begin
         off = int'(wr_addr - 32'h400);
         if (off < 32 && off / 4 < N && wr_strb[0]) nd[off / 4] = wr_data[7:0];
         if (off == 32 && wr_strb[0]) begin
            m_en = wr_data[0]; m_blank = wr_data[1];
         end
`ifdef SEG7_HEX_DECODE_EN
         if (off == 36)
            for (int k = 0; k < N; k++) nd[k] = {1'b0, hex_tab[(wr_data >> (4 * k)) & 32'hF]};
`endif
      end
      e_upd = 1'b0;
      for (int k = 0; k < N; k++) if (nd[k] != m_dig[k]) e_upd = 1'b1;
      m_dig = nd;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      step();
   endtask

   task automatic do_read(input logic [31:0] a);
      rd_en = 1'b1; rd_addr = a;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; wr_strb = 4'h0; rd_addr = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (an !== 4'b0000) begin errors++; $display("FAIL reset_an got=%b exp=0000", an); end
      checks++; if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg got=%h exp=00", seg); end
      checks++; if (upd !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_pulses upd=%b rv=%b exp=0", upd, rd_valid); end
      rst = 1'b0;
      do_read(32'h420);
      checks++; if (rd_valid !== 1'b1 || rd_data !== e_rd || e_rd !== 32'h1) begin
         errors++; $display("FAIL reset_ctrl_read got=%h rv=%b exp=00000001", rd_data, rd_valid); end
   endtask

   task automatic test_store();
      do_write(32'h400, 32'h5B, 4'h1);
      checks++; if (upd !== e_upd || e_upd !== 1'b1) begin errors++; $display("FAIL store_upd got=%b exp=1", upd); end
      do_read(32'h400);
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL store_upd_single got=%b exp=0", upd); end
      checks++; if (rd_data !== e_rd || rd_valid !== 1'b1) begin errors++; $display("FAIL store_read got=%h exp=%h", rd_data, e_rd); end
      for (int i = 0; i < 2 * N * SD; i++) begin
         step();
         if (e_an == 4'b0001) begin
            checks++; if (an !== 4'b0001 || seg !== 7'h5B) begin
               errors++; $display("FAIL store_seg an=%b seg=%h exp an=0001 seg=5b", an, seg); end
         end
      end
   endtask

   task automatic test_scan();
      rst = 1'b1; #2; rst = 1'b0; model_reset();
      for (int i = 0; i < 5 * SD; i++) begin
         step();
         checks++; if (an !== e_an || an !== 4'(1 << ((i / SD) % N))) begin
            errors++; $display("FAIL scan_an cycle=%0d got=%b exp=%b", i, an, e_an); end
      end
   endtask

   task automatic test_out_of_range();
      do_write(32'h400, 32'h5B, 4'h1);
      do_write(32'h400, 32'h5B, 4'h1);
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL same_value_upd got=%b exp=0", upd); end
      do_write(32'h410, 32'h06, 4'h1);
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL oor_upd got=%b exp=0", upd); end
      do_write(32'h404, 32'h6D, 4'hE);
      checks++; if (upd !== 1'b0) begin errors++; $display("FAIL nostrb_upd got=%b exp=0", upd); end
      do_read(32'h410);
      checks++; if (rd_data !== 32'd0 || rd_valid !== 1'b1) begin errors++; $display("FAIL oor_read got=%h exp=0", rd_data); end
   endtask

   task automatic test_hex();
      do_write(32'h424, 32'h0000A930, 4'h0);
      checks++; if (upd !== e_upd) begin errors++; $display("FAIL hex_upd got=%b exp=%b", upd, e_upd); end
      for (int k = 0; k < N; k++) begin
         do_read(32'h400 + 32'(4 * k));
         checks++; if (rd_data !== e_rd) begin errors++; $display("FAIL hex_digit%0d got=%h exp=%h", k, rd_data, e_rd); end
      end
      do_read(32'h424);
      checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL hex_read got=%h exp=0", rd_data); end
   endtask

   task automatic test_async_reset();
      repeat (6) step();
      #2; rst = 1'b1; #1;
      checks++; if (an !== 4'b0000 || seg !== 7'h00 || dp !== 1'b0) begin
         errors++; $display("FAIL async_reset an=%b seg=%h dp=%b exp all 0", an, seg, dp); end
      checks++; if (upd !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
         errors++; $display("FAIL async_reset_bus upd=%b rv=%b rd=%h exp 0", upd, rd_valid, rd_data); end
      @(posedge clk); #1; rst = 1'b0; model_reset();
      step();
      checks++; if (an !== 4'b0001) begin errors++; $display("FAIL post_reset_an got=%b exp=0001", an); end
   endtask

   task automatic test_disable();
      do_write(32'h420, 32'h0, 4'h1);
      for (int i = 0; i < 3 * SD; i++) begin
         step();
         checks++; if (an !== e_an) begin errors++; $display("FAIL disable_an got=%b exp=%b", an, e_an); end
      end
      do_write(32'h420, 32'h1, 4'h1);
      for (int i = 0; i < 2 * SD; i++) begin
         step();
         checks++; if (an !== e_an) begin errors++; $display("FAIL reenable_an got=%b exp=%b", an, e_an); end
      end
      do_write(32'h420, 32'h3, 4'h1);
      for (int i = 0; i < SD; i++) begin
         step();
         checks++; if (an !== e_an) begin errors++; $display("FAIL blank_an got=%b exp=%b", an, e_an); end
      end
      do_write(32'h420, 32'h1, 4'h1);
      for (int i = 0; i < N * SD; i++) begin
         step();
         checks++; if (an !== e_an) begin errors++; $display("FAIL unblank_an got=%b exp=%b", an, e_an); end
      end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 15);
         wr_en   = ($urandom_range(0, 1) == 1);
         wr_addr = (($urandom_range(0, 9) == 0) ? 32'h480 : 32'h400) + 32'(4 * r);
         wr_data = $urandom;
         if ($urandom_range(0, 1) == 1) wr_data[7:0] = 8'($urandom_range(0, 3));
         if (r == 8 && $urandom_range(0, 3) != 0) wr_data[0] = 1'b1;
         wr_strb = 4'($urandom_range(0, 15));
         rd_en   = ($urandom_range(0, 1) == 1);
         rd_addr = (($urandom_range(0, 9) == 0) ? 32'h000 : 32'h400) + 32'(4 * $urandom_range(0, 15));
         step();
         checks++; if (an !== e_an) begin errors++; $display("FAIL rand_an i=%0d got=%b exp=%b", i, an, e_an); end
         checks++; if (upd !== e_upd) begin errors++; $display("FAIL rand_upd i=%0d got=%b exp=%b", i, upd, e_upd); end
         checks++; if (rd_valid !== e_rv) begin errors++; $display("FAIL rand_rv i=%0d got=%b exp=%b", i, rd_valid, e_rv); end
         if (e_rv) begin
            checks++; if (rd_data !== e_rd) begin errors++; $display("FAIL rand_rd i=%0d got=%h exp=%h", i, rd_data, e_rd); end
         end
         if (e_an != 4'b0000) begin
            checks++; if (seg !== e_seg || dp !== e_dp) begin
               errors++; $display("FAIL rand_seg i=%0d got=%h/%b exp=%h/%b", i, seg, dp, e_seg, e_dp); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_scan();
      test_out_of_range();
      test_hex();
      test_async_reset();
      test_disable();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
